// File: rtl/dram_device_model.sv
// rtl/dram_device_model.sv - DRAM device responder: command decode, per-bank open row, data array, refresh FSM.
module dram_device_model #(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int NUMBER_OF_ROWS    = 128,
  parameter int NUMBER_OF_BANKS   = 8,
  parameter int DRAM_DATA_WIDTH   = 8,
  parameter int REFRESH_CYCLES    = 4,
  localparam int COLUMN_WIDTH     = $clog2(NUMBER_OF_COLUMNS),
  localparam int ROW_WIDTH        = $clog2(NUMBER_OF_ROWS),
  localparam int BANK_ID_WIDTH    = $clog2(NUMBER_OF_BANKS),
  localparam int DRAM_ADDR_WIDTH  = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH
) (
  input  logic                       u_clk,
  input  logic                       u_rst_n,
  input  logic                       dram_clk_en,
  input  logic                       dram_cs_n,
  input  logic                       dram_ras_n,
  input  logic                       dram_cas_n,
  input  logic                       dram_we_n,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
  input  logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
  output logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
  output logic                       dram_refresh_done,
  output logic                       dram_err
);

  localparam int CNT_WIDTH = $clog2(REFRESH_CYCLES + 1);
  localparam int IDX_WIDTH = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;

  typedef enum logic {R_IDLE, R_BUSY} refresh_state_e;
  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_PRE, CMD_RD, CMD_WR, CMD_REF} cmd_e;

  refresh_state_e state_q, state_d;
  cmd_e cmd;

  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [NUMBER_OF_BANKS-1:0] bank_open_q, bank_open_d;
  logic [ROW_WIDTH-1:0]       open_row_q [NUMBER_OF_BANKS];
  logic [ROW_WIDTH-1:0]       open_row_d [NUMBER_OF_BANKS];
  logic [DRAM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       wr_en;
  logic [IDX_WIDTH-1:0]       cur_idx;
  logic [DRAM_DATA_WIDTH-1:0] mem_q [2**IDX_WIDTH];

  always_comb begin
    cmd = CMD_NOP;
    if (!dram_cs_n) begin
      case ({dram_ras_n, dram_cas_n, dram_we_n})
        3'b011:  cmd = CMD_ACT;
        3'b010:  cmd = CMD_PRE;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b001:  cmd = CMD_REF;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  assign cur_idx = {dram_bank_id, open_row_q[dram_bank_id], dram_addr[COLUMN_WIDTH-1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    rd_data_d   = rd_data_q;
    err_d       = err_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    if (dram_clk_en) begin
      if (state_q == R_BUSY) begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = R_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        // A held REFRESH is a continuation; any other real command is illegal while busy.
        if (cmd == CMD_ACT || cmd == CMD_PRE || cmd == CMD_RD || cmd == CMD_WR) err_d = 1'b1;
      end else begin
        case (cmd)
          CMD_ACT: begin
            if (bank_open_q[dram_bank_id]) begin
              err_d = 1'b1;
            end else begin
              bank_open_d[dram_bank_id] = 1'b1;
              open_row_d[dram_bank_id]  = dram_addr[ROW_WIDTH-1:0];
            end
          end
          CMD_PRE: bank_open_d[dram_bank_id] = 1'b0;
          CMD_RD: begin
            if (bank_open_q[dram_bank_id]) rd_data_d = mem_q[cur_idx];
            else err_d = 1'b1;
          end
          CMD_WR: begin
            if (bank_open_q[dram_bank_id]) wr_en = 1'b1;
            else err_d = 1'b1;
          end
          CMD_REF: begin
            if (!done_q) begin
              state_d     = R_BUSY;
              cnt_d       = CNT_WIDTH'(REFRESH_CYCLES - 1);
              bank_open_d = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      state_q     <= R_IDLE;
      cnt_q       <= '0;
      bank_open_q <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int b = 0; b < NUMBER_OF_BANKS; b++) open_row_q[b] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bank_open_q <= bank_open_d;
      open_row_q  <= open_row_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Array contents survive reset, so the storage has no reset branch.
  always_ff @(posedge u_clk) begin
    if (wr_en) mem_q[cur_idx] <= dram_wr_data;
  end

  assign dram_rd_data      = rd_data_q;
  assign dram_refresh_done = done_q;
  assign dram_err          = err_q;

endmodule

// File: tb/tb_dram_device_model.sv
// tb/tb_dram_device_model.sv - scoreboard bench for dram_device_model.
module tb_dram_device_model;

  localparam logic [3:0] C_NOP = 4'b1111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_REF = 4'b0001;

  logic       u_clk, u_rst_n, dram_clk_en;
  logic       dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
  logic [6:0] dram_addr;
  logic [2:0] dram_bank_id;
  logic [7:0] dram_wr_data, dram_rd_data;
  logic       dram_refresh_done, dram_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];

  dram_device_model dut (
    .u_clk(u_clk), .u_rst_n(u_rst_n), .dram_clk_en(dram_clk_en),
    .dram_cs_n(dram_cs_n), .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n), .dram_we_n(dram_we_n),
    .dram_addr(dram_addr), .dram_bank_id(dram_bank_id), .dram_wr_data(dram_wr_data),
    .dram_rd_data(dram_rd_data), .dram_refresh_done(dram_refresh_done), .dram_err(dram_err)
  );

  initial u_clk = 1'b0;
  always #5 u_clk = ~u_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [2:0] b, input logic [6:0] a, input logic [7:0] d);
    {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = c;
    dram_bank_id = b;
    dram_addr    = a;
    dram_wr_data = d;
    @(posedge u_clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [2:0] b, input logic [6:0] col, input logic [7:0] exp);
    exp_q.push_back(exp);
    drive(C_RD, b, col, 8'h00);
    if (exp_q.size() == 0) check_eq({tag, "_empty"}, 32'd0, 32'd1);
    else check_eq(tag, dram_rd_data, exp_q.pop_front());
  endtask

  initial begin
    logic seen;
    u_rst_n = 1'b0;
    dram_clk_en = 1'b1;
    {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = C_NOP;
    dram_addr = '0; dram_bank_id = '0; dram_wr_data = '0;
    @(posedge u_clk); #1;
    check_eq("reset_rd_data", dram_rd_data, 0);
    check_eq("reset_done", dram_refresh_done, 0);
    check_eq("reset_err", dram_err, 0);
    u_rst_n = 1'b1;
    drive(C_NOP, 0, 0, 0);

    // basic write / read-after-write
    drive(C_ACT, 3, 5, 0);
    drive(C_WR, 3, 2, 8'hA5);
    rd("t1_read", 3, 2, 8'hA5);
    check_eq("t1_err", dram_err, 0);

    // row isolation within a bank
    drive(C_PRE, 3, 0, 0);
    drive(C_ACT, 0, 1, 0);  drive(C_WR, 0, 4, 8'h11); drive(C_PRE, 0, 0, 0);
    drive(C_ACT, 0, 2, 0);  drive(C_WR, 0, 4, 8'h22); drive(C_PRE, 0, 0, 0);
    drive(C_ACT, 0, 1, 0);  rd("t2_row1", 0, 4, 8'h11); drive(C_PRE, 0, 0, 0);
    drive(C_ACT, 0, 2, 0);  rd("t2_row2", 0, 4, 8'h22);
    check_eq("t2_err", dram_err, 0);

    // clk_en gap of 3 cycles mid-refresh stretches completion by 3
    drive(C_REF, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      dram_clk_en = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
      drive(C_NOP, 0, 0, 0);
      check_eq($sformatf("t5_done_k%0d", k), dram_refresh_done, (k == 7));
    end
    dram_clk_en = 1'b1;
    drive(C_NOP, 0, 0, 0);
    check_eq("t5_err", dram_err, 0);

    // held REFRESH: single pulse, then re-accepted once done has dropped
    drive(C_ACT, 1, 3, 0);
    drive(C_ACT, 4, 6, 0);
    for (int i = 0; i < 8; i++) begin
      drive(C_REF, 0, 0, 0);
      check_eq($sformatf("t3_done_i%0d", i), dram_refresh_done, (i == 4));
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      drive(C_NOP, 0, 0, 0);
      seen = dram_refresh_done;
    end
    check_eq("t3_second_done", seen, 1);
    check_eq("t3_err_clean", dram_err, 0);
    drive(C_RD, 1, 0, 0);
    check_eq("t3_rd_closed_err", dram_err, 1);

    u_rst_n = 1'b0;
    drive(C_NOP, 0, 0, 0);
    u_rst_n = 1'b1;
    check_eq("rst_err_clear", dram_err, 0);

    // closed-bank read and double activate
    drive(C_ACT, 2, 10, 0);
    drive(C_WR, 2, 0, 8'h5A);
    rd("t4_read", 2, 0, 8'h5A);
    check_eq("t4_err0", dram_err, 0);
    drive(C_RD, 6, 0, 0);
    check_eq("t4_closed_err", dram_err, 1);
    check_eq("t4_rd_hold", dram_rd_data, 8'h5A);
    drive(C_ACT, 2, 11, 0);
    drive(C_WR, 2, 1, 8'h77);
    drive(C_PRE, 2, 0, 0);
    drive(C_ACT, 2, 10, 0);
    rd("t4_row_kept", 2, 1, 8'h77);

    // async reset mid-refresh
    drive(C_ACT, 5, 100, 0);
    drive(C_WR, 5, 7, 8'hC3);
    drive(C_REF, 0, 0, 0);
    drive(C_NOP, 0, 0, 0);
    drive(C_NOP, 0, 0, 0);
    #2;
    u_rst_n = 1'b0;
    #1;
    check_eq("t6_done", dram_refresh_done, 0);
    check_eq("t6_err", dram_err, 0);
    check_eq("t6_rd_data", dram_rd_data, 0);
    @(posedge u_clk); #1;
    u_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(C_NOP, 0, 0, 0);
      seen = seen | dram_refresh_done;
    end
    check_eq("t6_no_pulse", seen, 0);
    drive(C_ACT, 5, 100, 0);
    rd("t6_retained", 5, 7, 8'hC3);
    check_eq("t6_err_after", dram_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
